mcpu_ctrl: RTL and testbench

MCPU_CTRL -- requirements
Module: mcpu_ctrl

---
 rtl/mcpu_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle MIPS-subset control FSM (fetch, decode, execute, memory, write-back).
// Ports:
//   clk, rst (async, active-low)         clock and reset
//   opcode, funct, zero, mio_ready       instruction fields, ALU zero flag, memory handshake
//   mem_r, mem_w, iord                   memory strobes and address select
//   ir_ce, mdr_ce, ab_ce, aluout_ce,     datapath register clock enables
//   pc_ce
//   alu_src_a, alu_src_b, alu_ctrl       ALU operand selects and operation
//   pc_src, reg_dst, mem_to_reg,         PC source, register-file destination / source / write
//   reg_write, ext_zero                  and immediate zero-extension
//   state, illegal_op                    current state and sticky decode-error flag
module mcpu_ctrl #(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mio_ready,
   output logic       mem_r,
   output logic       mem_w,
   output logic       iord,
   output logic       ir_ce,
   output logic       mdr_ce,
   output logic       ab_ce,
   output logic       aluout_ce,
   output logic       pc_ce,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_src,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       ext_zero,
   output logic [3:0] state,
   output logic       illegal_op
);
   localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_MA = 4'd2, S_LW_RD = 4'd3, S_LW_WB = 4'd4,
                          S_SW = 4'd5, S_R_EX = 4'd6, S_R_WB = 4'd7, S_BR = 4'd8, S_J = 4'd9,
                          S_I_EX = 4'd10, S_I_WB = 4'd11, S_JAL = 4'd12, S_JR = 4'd13, S_ERR = 4'd14;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                          OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                          OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, FN_JR = 6'h08;
   logic [3:0] state_q, state_d;
   logic       illegal_q, illegal_d;
   logic       rdy;
   logic       r_ok;
   logic [2:0] r_op;

   // With MEM_WAIT=0 every memory access completes in its first cycle.
   assign rdy = (MEM_WAIT == 0) | mio_ready;
   assign state = state_q;
   assign illegal_op = illegal_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IF;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // R-type funct decode: ALU op plus a flag saying the funct is supported.
   always_comb begin
      r_op = 3'b000;
      r_ok = 1'b1;
      case (funct)
         6'h20: r_op = 3'b010;
         6'h22: r_op = 3'b110;
         6'h24: r_op = 3'b000;
         6'h25: r_op = 3'b001;
         6'h26: r_op = 3'b011;
         6'h27: r_op = 3'b100;
         6'h2A: r_op = 3'b111;
         6'h02: r_op = 3'b101;
         default: r_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:    state_d = rdy ? S_ID : S_IF;
         S_ID:
            case (opcode)
               OP_R:                                    state_d = (funct == FN_JR) ? S_JR : S_R_EX;
               OP_LW, OP_SW:                            state_d = S_MA;
               OP_BEQ, OP_BNE:                          state_d = S_BR;
               OP_J:                                    state_d = S_J;
               OP_JAL:                                  state_d = S_JAL;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_I_EX;
               default:                                 state_d = S_ERR;
            endcase
         S_MA:    state_d = (opcode == OP_LW) ? S_LW_RD : S_SW;
         S_LW_RD: state_d = rdy ? S_LW_WB : S_LW_RD;
         S_SW:    state_d = rdy ? S_IF : S_SW;
         S_R_EX:  state_d = r_ok ? S_R_WB : S_ERR;
         S_I_EX:  state_d = S_I_WB;
         S_ERR:   state_d = S_ERR;
         // Remaining single-cycle states and the unused encoding 15 return to fetch.
         default: state_d = S_IF;
      endcase
   end

   assign illegal_d = illegal_q | (state_d == S_ERR);

   // Outputs are gated by rst so an in-flight access is dropped the moment reset asserts.
   always_comb begin
      mem_r      = 1'b0;
      mem_w      = 1'b0;
      iord       = 1'b0;
      ir_ce      = 1'b0;
      mdr_ce     = 1'b0;
      ab_ce      = 1'b0;
      aluout_ce  = 1'b0;
      pc_ce      = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      pc_src     = 2'b00;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      reg_write  = 1'b0;
      ext_zero   = 1'b0;
      if (rst) begin
         case (state_q)
            S_IF: begin
               mem_r     = 1'b1;
               alu_src_b = 2'b01;
               alu_ctrl  = 3'b010;
               ir_ce     = rdy;
               pc_ce     = rdy;
            end
            S_ID: begin
               ab_ce     = 1'b1;
               aluout_ce = 1'b1;
               alu_src_b = 2'b11;
               alu_ctrl  = 3'b010;
            end
            S_MA: begin
               aluout_ce = 1'b1;
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctrl  = 3'b010;
            end
            S_LW_RD: begin
               iord   = 1'b1;
               mem_r  = 1'b1;
               mdr_ce = rdy;
            end
            S_LW_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'b01;
            end
            S_SW: begin
               iord  = 1'b1;
               mem_w = 1'b1;
            end
            S_R_EX: begin
               aluout_ce = 1'b1;
               alu_src_a = 1'b1;
               alu_ctrl  = r_op;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 2'b01;
            end
            S_BR: begin
               alu_src_a = 1'b1;
               alu_ctrl  = 3'b110;
               pc_src    = 2'b01;
               pc_ce     = (opcode == OP_BEQ) ? zero : ~zero;
            end
            S_J: begin
               pc_ce  = 1'b1;
               pc_src = 2'b10;
            end
            S_JR: begin
               pc_ce  = 1'b1;
               pc_src = 2'b11;
            end
            S_JAL: begin
               pc_ce      = 1'b1;
               pc_src     = 2'b10;
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end
            S_I_EX: begin
               aluout_ce = 1'b1;
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctrl  = (opcode == OP_ADDI) ? 3'b010 :
                           (opcode == OP_ORI)  ? 3'b001 :
                           (opcode == OP_SLTI) ? 3'b111 : 3'b000;
               ext_zero  = (opcode == OP_ANDI) | (opcode == OP_ORI);
            end
            S_I_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (opcode == OP_LUI) ? 2'b11 : 2'b00;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: scoreboard bench; an instruction-level model turns each instruction into its expected cycle script.
module tb_mcpu_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic       zero = 1'b0, mio_ready = 1'b0;
   logic       mem_r, mem_w, iord, ir_ce, mdr_ce, ab_ce, aluout_ce, pc_ce, alu_src_a;
   logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
   logic [2:0] alu_ctrl;
   logic       reg_write, ext_zero, illegal_op;
   logic [3:0] state;

   typedef struct packed {
      logic       mem_r, mem_w, iord, ir_ce, mdr_ce, ab_ce, aluout_ce, pc_ce, alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [1:0] pc_src, reg_dst, mem_to_reg;
      logic       reg_write, ext_zero;
      logic [3:0] state;
      logic       illegal_op;
   } out_t;

   out_t act, exp_v;
   out_t exp_q[$];
   int   n_cmp = 0, n_err = 0;
   bit   ill = 1'b0;

   always #5 clk = ~clk;

   mcpu_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mio_ready(mio_ready),
      .mem_r(mem_r), .mem_w(mem_w), .iord(iord), .ir_ce(ir_ce), .mdr_ce(mdr_ce), .ab_ce(ab_ce),
      .aluout_ce(aluout_ce), .pc_ce(pc_ce), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctrl(alu_ctrl), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .ext_zero(ext_zero), .state(state), .illegal_op(illegal_op)
   );

   assign act = {mem_r, mem_w, iord, ir_ce, mdr_ce, ab_ce, aluout_ce, pc_ce, alu_src_a, alu_src_b,
                 alu_ctrl, pc_src, reg_dst, mem_to_reg, reg_write, ext_zero, state, illegal_op};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_cmp++;
         if (act !== exp_v) begin
            n_err++;
            $display("FAIL outputs in state %0d (op %h fn %h): got %h, want %h", exp_v.state, opcode, funct, act, exp_v);
         end
      end
   end

   function automatic logic rr();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic out_t base(input logic [3:0] st);
      out_t e = '0;
      e.state = st;
      e.illegal_op = ill;
      return e;
   endfunction

   // {supported, alu op} for an R-type funct
   function automatic logic [3:0] r_alu(input logic [5:0] f);
      case (f)
         6'h20: return 4'b1010;
         6'h22: return 4'b1110;
         6'h24: return 4'b1000;
         6'h25: return 4'b1001;
         6'h26: return 4'b1011;
         6'h27: return 4'b1100;
         6'h2A: return 4'b1111;
         6'h02: return 4'b1101;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic cyc(input out_t e, input logic rdy);
      mio_ready = rdy;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      zero = rr();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      ill = 1'b0;
      for (int i = 0; i < n; i++) cyc(base(4'd0), rr());
      rst = 1'b1;
   endtask

   task automatic to_err();
      ill = 1'b1;
      for (int i = 0; i < 3; i++) cyc(base(4'd14), rr());
      do_reset(2);
   endtask

   // mw < 0: random fetch and memory waits; otherwise no fetch wait and mw memory waits.
   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int mw, input bit abort);
      out_t e;
      int w;
      logic [3:0] ra;
      opcode = op;
      funct = fn;
      w = (mw < 0) ? int'($urandom_range(0, 2)) : 0;
      for (int i = 0; i <= w; i++) begin
         e = base(4'd0); e.mem_r = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
         e.ir_ce = (i == w); e.pc_ce = (i == w);
         cyc(e, i == w);
      end
      e = base(4'd1); e.ab_ce = 1'b1; e.aluout_ce = 1'b1; e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010;
      cyc(e, rr());
      w = (mw < 0) ? int'($urandom_range(0, 2)) : mw;
      case (op)
         6'h00:
            if (fn == 6'h08) begin
               e = base(4'd13); e.pc_ce = 1'b1; e.pc_src = 2'b11; cyc(e, rr());
            end else begin
               ra = r_alu(fn);
               e = base(4'd6); e.aluout_ce = 1'b1; e.alu_src_a = 1'b1; e.alu_ctrl = ra[2:0]; cyc(e, rr());
               if (ra[3]) begin
                  e = base(4'd7); e.reg_write = 1'b1; e.reg_dst = 2'b01; cyc(e, rr());
               end else to_err();
            end
         6'h23, 6'h2B: begin
            e = base(4'd2); e.aluout_ce = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010;
            cyc(e, rr());
            for (int i = 0; i <= w; i++) begin
               if (abort && i == 1) begin
                  do_reset(2);
                  return;
               end
               e = base((op == 6'h23) ? 4'd3 : 4'd5); e.iord = 1'b1;
               e.mem_r = (op == 6'h23); e.mem_w = (op == 6'h2B); e.mdr_ce = (op == 6'h23) && (i == w);
               cyc(e, i == w);
            end
            if (op == 6'h23) begin
               e = base(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 2'b01; cyc(e, rr());
            end
         end
         6'h04, 6'h05: begin
            e = base(4'd8); e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
            e.pc_ce = (op == 6'h04) ? zero : ~zero;
            cyc(e, rr());
         end
         6'h02: begin
            e = base(4'd9); e.pc_ce = 1'b1; e.pc_src = 2'b10; cyc(e, rr());
         end
         6'h03: begin
            e = base(4'd12); e.pc_ce = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1;
            e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; cyc(e, rr());
         end
         6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F: begin
            e = base(4'd10); e.aluout_ce = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            e.alu_ctrl = (op == 6'h08) ? 3'b010 : (op == 6'h0D) ? 3'b001 : (op == 6'h0A) ? 3'b111 : 3'b000;
            e.ext_zero = (op == 6'h0C) || (op == 6'h0D);
            cyc(e, rr());
            e = base(4'd11); e.reg_write = 1'b1; e.mem_to_reg = (op == 6'h0F) ? 2'b11 : 2'b00; cyc(e, rr());
         end
         default: to_err();
      endcase
   endtask

   logic [5:0] ops [13] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F};
   logic [5:0] fns [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h08};

   initial begin
      logic [5:0] op, fn;
      @(posedge clk);
      #1;
      cyc(base(4'd0), 1'b1);
      cyc(base(4'd0), 1'b0);
      rst = 1'b1;
      do_instr(6'h00, 6'h20, 0, 1'b0);
      do_instr(6'h23, 6'h00, 2, 1'b0);
      for (int i = 0; i < 4; i++) do_instr(6'h04, 6'h00, 0, 1'b0);
      for (int i = 0; i < 4; i++) do_instr(6'h05, 6'h00, 0, 1'b0);
      do_instr(6'h03, 6'h00, 0, 1'b0);
      do_instr(6'h3F, 6'h00, 0, 1'b0);
      do_instr(6'h2B, 6'h00, 2, 1'b1);
      do_instr(6'h00, 6'h3F, -1, 1'b0);
      do_instr(6'h0F, 6'h00, -1, 1'b0);
      for (int n = 0; n < 300; n++) begin
         op = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 12)];
         fn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 8)];
         do_instr(op, fn, -1, 1'b0);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
